sti_rx: RTL and testbench
=========================

// Module: sti_rx
// PURPOSE
// - Serial-to-parallel receiver at the far end of the STI link: samples so_data/so_valid-style bit stream,
//   reassembles 8/16/24/32-bit frames, strips fill/padding, delivers 16-bit words on a one-cycle strobe.
// - Used for loop-back checking of STI_DAC and as the ingest stage of downstream data consumers.
// PARAMETERS
// - CNT_W      16  width of received-frame counter frame_cnt (wraps).
// PORTS
// - clk        in   1   single clock, all logic on rising edge.
// - reset      in   1   asynchronous, active-low (0 = reset asserted); release synchronous to clk.
// - si_data    in   1   serial data bit, sampled when si_valid=1.
// - si_valid   in   1   bit-valid; high for consecutive cycles across a frame.
// - si_end     in   1   end-of-stream marker from sender.
// - cfg_length in   2   00=8b, 01=16b, 10=24b, 11=32b frame.
// - cfg_msb    in   1   1=first bit is frame MSB, 0=first bit is frame LSB.
// - cfg_fill   in   1   24/32b only: 1=payload in frame MSBs, 0=payload in frame LSBs.
// - cfg_low    in   1   8b only: 1=byte placed in po_data[15:8], 0=in po_data[7:0].
// - po_data    out  16  recovered word, held until next po_valid.
// - po_valid   out  1   one-cycle strobe, po_data valid.
// - pad_err    out  1   qualifies po_valid: padding bits were not all zero.
// - frame_err  out  1   one-cycle pulse: si_valid dropped before frame complete.
// - frame_cnt  out  CNT_W  count of good frames delivered (incl. pad_err frames).
// - rx_done    out  1   sticky: si_end seen while IDLE.
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, shift reg/bit counter cleared. Reset mid-frame discards frame, no strobe.
// - FSM IDLE: on si_valid=1 latch cfg_* (ignored until next frame start), shift in bit, bit_cnt=1, go RECV.
//   N=8/16/24/32 per latched length; cfg changes during RECV have no effect.
// - RECV: each si_valid=1 cycle shifts one bit (msb-first: shift left; lsb-first: insert at bit_cnt position).
//   On Nth bit: go IDLE, register po_data/po_valid/pad_err at next edge (po_valid high exactly the cycle
//   after the cycle in which Nth bit sampled: latency 1).
//   si_valid=0 with 0<bit_cnt<N: frame_err pulse next cycle, discard, go IDLE; no po_valid, frame_cnt unchanged.
// - Back-to-back: si_valid high in cycle after Nth bit starts new frame (IDLE path, cfg re-latched);
//   po_valid of previous frame coincides with first bit of next frame; no bit lost.
// - Unpack (frame b[N-1:0]): 8b: cfg_low?{b,8'h00}:{8'h00,b}; 16b: b; 24b fill=1: b[23:8], pad b[7:0];
//   24b fill=0: b[15:0], pad b[23:16]; 32b fill=1: b[31:16], pad b[15:0]; fill=0: b[15:0], pad b[31:16].
//   pad_err=|pad, sampled with po_valid; word still delivered.
// - frame_cnt += 1 per po_valid, wraps at 2^CNT_W modulo.
// - rx_done set when si_end=1 and FSM in IDLE (incl. cycle of final po_valid); cleared only by reset.
//   si_end during RECV ignored; partial-frame abort then follows frame_err rule.
// - Simultaneous frame_err and po_valid impossible (exclusive by FSM); document as assertion.
// STRUCTURE
// - Shared package sti_pkg: length encodings (LEN_8/16/24/32), frame_bits(len) function, FSM state enum
//   {IDLE,RECV}; same package reused by STI transmit side.
// - Sub-module sti_rx_unpack: combinational frame-to-word extractor + pad check (inputs frame, latched cfg).
// - Top: FSM, 32b shift register, 6b bit counter, output registers, frame counter.
// TESTING
// - 16b msb-first 0xA5C3 -> po_valid 1 cycle after 16th bit, po_data=0xA5C3, pad_err=0, frame_cnt=1.
// - 8b lsb-first cfg_low=1 byte 0x3C -> po_data=0x3C00; same with cfg_low=0 -> 0x003C.
// - 32b fill=0 frame 0x0000_1234 -> 0x1234 pad_err=0; frame 0x8000_1234 -> 0x1234 pad_err=1.
// - 24b frame, si_valid drops after 10 bits -> frame_err pulse, no po_valid; next 16b 0xBEEF received intact.
// - Two 8b frames 0x11,0x22 with si_valid continuous 16 cycles -> two po_valid pulses 8 cycles apart.
// - reset=0 mid-32b frame -> all outputs 0 immediately; after release si_end=1 in IDLE -> rx_done=1 sticky.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared STI definitions: frame length encodings, frame size helper and link FSM states.
// Also imported by the transmit side.
package sti_pkg;

   localparam logic [1:0] LEN_8  = 2'b00;
   localparam logic [1:0] LEN_16 = 2'b01;
   localparam logic [1:0] LEN_24 = 2'b10;
   localparam logic [1:0] LEN_32 = 2'b11;

   typedef enum logic {IDLE, RECV} sti_state_e;

   function automatic logic [5:0] frame_bits(input logic [1:0] len);
      logic [5:0] n;
      unique case (len)
         LEN_8:   n = 6'd8;
         LEN_16:  n = 6'd16;
         LEN_24:  n = 6'd24;
         default: n = 6'd32;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sti_rx_unpack.sv
// Combinational frame-to-word extractor: picks the 16-bit payload out of a received
// frame and flags non-zero padding.
module sti_rx_unpack
   import sti_pkg::*;
(
   input  logic [31:0] frame,
   input  logic [1:0]  len,
   input  logic        fill,
   input  logic        low,
   output logic [15:0] word,
   output logic        pad_err
);

   always_comb begin
      word    = 16'h0000;
      pad_err = 1'b0;
      unique case (len)
         LEN_8:  word = low ? {frame[7:0], 8'h00} : {8'h00, frame[7:0]};
         LEN_16: word = frame[15:0];
         LEN_24: begin
            if (fill) begin
               word    = frame[23:8];
               pad_err = |frame[7:0];
            end else begin
               word    = frame[15:0];
               pad_err = |frame[23:16];
            end
         end
         default: begin
            if (fill) begin
               word    = frame[31:16];
               pad_err = |frame[15:0];
            end else begin
               word    = frame[15:0];
               pad_err = |frame[31:16];
            end
         end
      endcase
   end

endmodule

// File: rtl/sti_rx.sv
// STI serial receiver: reassembles 8/16/24/32-bit frames from a valid-qualified bit
// stream and delivers 16-bit words on a one-cycle strobe.
module sti_rx
   import sti_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             si_data,
   input  logic             si_valid,
   input  logic             si_end,
   input  logic [1:0]       cfg_length,
   input  logic             cfg_msb,
   input  logic             cfg_fill,
   input  logic             cfg_low,
   output logic [15:0]      po_data,
   output logic             po_valid,
   output logic             pad_err,
   output logic             frame_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             rx_done
);

   sti_state_e       state_q, state_d;
   logic [31:0]      sr_q, sr_d, sr_next;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic [1:0]       len_q, len_d;
   logic             msb_q, msb_d, fill_q, fill_d, low_q, low_d;
   logic [15:0]      po_data_q, po_data_d;
   logic             po_valid_q, po_valid_d;
   logic             pad_err_q, pad_err_d;
   logic             frame_err_q, frame_err_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             rx_done_q, rx_done_d;
   logic [15:0]      unp_word;
   logic             unp_pad;

   // Frame contents including the bit sampled this cycle, so the word is ready at the Nth edge.
   always_comb begin
      sr_next = sr_q;
      if (msb_q) begin
         sr_next = {sr_q[30:0], si_data};
      end else begin
         sr_next[bit_cnt_q[4:0]] = si_data;
      end
   end

   sti_rx_unpack u_unpack (
      .frame   (sr_next),
      .len     (len_q),
      .fill    (fill_q),
      .low     (low_q),
      .word    (unp_word),
      .pad_err (unp_pad)
   );

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      len_d       = len_q;
      msb_d       = msb_q;
      fill_d      = fill_q;
      low_d       = low_q;
      po_data_d   = po_data_q;
      po_valid_d  = 1'b0;
      pad_err_d   = pad_err_q;
      frame_err_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      rx_done_d   = rx_done_q | (si_end && (state_q == IDLE));
      unique case (state_q)
         IDLE: begin
            if (si_valid) begin
               len_d     = cfg_length;
               msb_d     = cfg_msb;
               fill_d    = cfg_fill;
               low_d     = cfg_low;
               sr_d      = {31'd0, si_data};
               bit_cnt_d = 6'd1;
               state_d   = RECV;
            end
         end
         default: begin
            if (si_valid) begin
               sr_d      = sr_next;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == frame_bits(len_q) - 6'd1) begin
                  state_d     = IDLE;
                  bit_cnt_d   = 6'd0;
                  po_valid_d  = 1'b1;
                  po_data_d   = unp_word;
                  pad_err_d   = unp_pad;
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d     = IDLE;
               sr_d        = 32'd0;
               bit_cnt_d   = 6'd0;
               frame_err_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         sr_q        <= 32'd0;
         bit_cnt_q   <= 6'd0;
         len_q       <= LEN_8;
         msb_q       <= 1'b0;
         fill_q      <= 1'b0;
         low_q       <= 1'b0;
         po_data_q   <= 16'h0000;
         po_valid_q  <= 1'b0;
         pad_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
         rx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         len_q       <= len_d;
         msb_q       <= msb_d;
         fill_q      <= fill_d;
         low_q       <= low_d;
         po_data_q   <= po_data_d;
         po_valid_q  <= po_valid_d;
         pad_err_q   <= pad_err_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
         rx_done_q   <= rx_done_d;
      end
   end

   assign po_data   = po_data_q;
   assign po_valid  = po_valid_q;
   assign pad_err   = pad_err_q;
   assign frame_err = frame_err_q;
   assign frame_cnt = frame_cnt_q;
   assign rx_done   = rx_done_q;

   // A frame either completes or aborts, never both in the same cycle.
   a_strobe_excl: assert property (@(posedge clk) disable iff (!reset) !(po_valid && frame_err));

endmodule

// File: tb/tb_sti_rx.sv
// Directed self-checking bench for sti_rx: one task per scenario, hand-computed expectations.
module tb_sti_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        si_data, si_valid, si_end;
   logic [1:0]  cfg_length;
   logic        cfg_msb, cfg_fill, cfg_low;
   logic [15:0] po_data;
   logic        po_valid, pad_err, frame_err, rx_done;
   logic [15:0] frame_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sti_rx #(.CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .si_data    (si_data),
      .si_valid   (si_valid),
      .si_end     (si_end),
      .cfg_length (cfg_length),
      .cfg_msb    (cfg_msb),
      .cfg_fill   (cfg_fill),
      .cfg_low    (cfg_low),
      .po_data    (po_data),
      .po_valid   (po_valid),
      .pad_err    (pad_err),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt),
      .rx_done    (rx_done)
   );

   task automatic send_bit(input logic b);
      si_valid = 1'b1;
      si_data  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      si_valid = 1'b0;
      si_data  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Sends the first cnt bits of an n-bit frame in link order.
   task automatic send_bits(input logic [31:0] v, input int n, input logic msb, input int cnt);
      for (int i = 0; i < cnt; i++) send_bit(msb ? v[n-1-i] : v[i]);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (po_data !== 16'h0000) $display("FAIL reset_po_data: got %h expected 0000", po_data);
      else pass_cnt++;
      total_cnt++;
      if ({po_valid, pad_err, frame_err, rx_done} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000", {po_valid, pad_err, frame_err, rx_done});
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
      else pass_cnt++;
      reset = 1'b1;
      idle_cycle();
   endtask

   task automatic test_16b_msb();
      logic [31:0] v;
      v = 32'h0000_A5C3;
      cfg_length = 2'b01; cfg_msb = 1'b1; cfg_fill = 1'b0; cfg_low = 1'b0;
      send_bits(v, 16, 1'b1, 15);
      total_cnt++;
      if (po_valid !== 1'b0) $display("FAIL b16_early_valid: got %b expected 0", po_valid);
      else pass_cnt++;
      send_bit(v[0]);
      total_cnt++;
      if (po_valid !== 1'b1 || po_data !== 16'hA5C3 || pad_err !== 1'b0)
         $display("FAIL b16_word: got v=%b d=%h p=%b expected v=1 d=a5c3 p=0",
                  po_valid, po_data, pad_err);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 16'd1) $display("FAIL b16_cnt: got %0d expected 1", frame_cnt);
      else pass_cnt++;
      idle_cycle();
      total_cnt++;
      if (po_valid !== 1'b0 || po_data !== 16'hA5C3)
         $display("FAIL b16_hold: got v=%b d=%h expected v=0 d=a5c3", po_valid, po_data);
      else pass_cnt++;
   endtask

   task automatic test_8b_lsb();
      logic [31:0] v;
      v = 32'h0000_003C;
      cfg_length = 2'b00; cfg_msb = 1'b0; cfg_low = 1'b1;
      send_bit(v[0]);
      // Mid-frame cfg changes must not affect the frame in progress.
      cfg_low = 1'b0; cfg_length = 2'b11;
      for (int i = 1; i < 8; i++) send_bit(v[i]);
      total_cnt++;
      if (po_valid !== 1'b1 || po_data !== 16'h3C00)
         $display("FAIL b8_low1: got v=%b d=%h expected v=1 d=3c00", po_valid, po_data);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 16'd2) $display("FAIL b8_cnt_a: got %0d expected 2", frame_cnt);
      else pass_cnt++;
      idle_cycle();
      cfg_length = 2'b00; cfg_low = 1'b0;
      send_bits(v, 8, 1'b0, 8);
      total_cnt++;
      if (po_valid !== 1'b1 || po_data !== 16'h003C || frame_cnt !== 16'd3)
         $display("FAIL b8_low0: got v=%b d=%h c=%0d expected v=1 d=003c c=3",
                  po_valid, po_data, frame_cnt);
      else pass_cnt++;
      idle_cycle();
   endtask

   task automatic test_pad();
      cfg_length = 2'b11; cfg_msb = 1'b1; cfg_fill = 1'b0;
      send_bits(32'h0000_1234, 32, 1'b1, 32);
      total_cnt++;
      if (po_valid !== 1'b1 || po_data !== 16'h1234 || pad_err !== 1'b0)
         $display("FAIL b32_clean: got v=%b d=%h p=%b expected v=1 d=1234 p=0",
                  po_valid, po_data, pad_err);
      else pass_cnt++;
      idle_cycle();
      send_bits(32'h8000_1234, 32, 1'b1, 32);
      total_cnt++;
      if (po_valid !== 1'b1 || po_data !== 16'h1234 || pad_err !== 1'b1)
         $display("FAIL b32_pad: got v=%b d=%h p=%b expected v=1 d=1234 p=1",
                  po_valid, po_data, pad_err);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 16'd5) $display("FAIL b32_cnt: got %0d expected 5", frame_cnt);
      else pass_cnt++;
      idle_cycle();
      cfg_length = 2'b10; cfg_msb = 1'b0; cfg_fill = 1'b1;
      send_bits(32'h00AB_CD01, 24, 1'b0, 24);
      total_cnt++;
      if (po_valid !== 1'b1 || po_data !== 16'hABCD || pad_err !== 1'b1 || frame_cnt !== 16'd6)
         $display("FAIL b24_fill1: got v=%b d=%h p=%b c=%0d expected v=1 d=abcd p=1 c=6",
                  po_valid, po_data, pad_err, frame_cnt);
      else pass_cnt++;
      idle_cycle();
   endtask

   task automatic test_frame_err();
      cfg_length = 2'b10; cfg_msb = 1'b1; cfg_fill = 1'b0;
      send_bits(32'h00FF_FFFF, 24, 1'b1, 10);
      idle_cycle();
      total_cnt++;
      if (frame_err !== 1'b1 || po_valid !== 1'b0)
         $display("FAIL ferr_pulse: got e=%b v=%b expected e=1 v=0", frame_err, po_valid);
      else pass_cnt++;
      idle_cycle();
      total_cnt++;
      if (frame_err !== 1'b0 || frame_cnt !== 16'd6)
         $display("FAIL ferr_after: got e=%b c=%0d expected e=0 c=6", frame_err, frame_cnt);
      else pass_cnt++;
      cfg_length = 2'b01;
      send_bits(32'h0000_BEEF, 16, 1'b1, 16);
      total_cnt++;
      if (po_valid !== 1'b1 || po_data !== 16'hBEEF || pad_err !== 1'b0 || frame_cnt !== 16'd7)
         $display("FAIL ferr_next: got v=%b d=%h p=%b c=%0d expected v=1 d=beef p=0 c=7",
                  po_valid, po_data, pad_err, frame_cnt);
      else pass_cnt++;
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      v = 16'h1122;
      cfg_length = 2'b00; cfg_msb = 1'b1; cfg_low = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send_bit(v[15-i]);
         if (i == 7) begin
            total_cnt++;
            if (po_valid !== 1'b1 || po_data !== 16'h0011)
               $display("FAIL b2b_first: got v=%b d=%h expected v=1 d=0011", po_valid, po_data);
            else pass_cnt++;
         end
         if (i == 8) begin
            total_cnt++;
            if (po_valid !== 1'b0) $display("FAIL b2b_gap: got %b expected 0", po_valid);
            else pass_cnt++;
         end
         if (i == 15) begin
            total_cnt++;
            if (po_valid !== 1'b1 || po_data !== 16'h0022 || frame_cnt !== 16'd9)
               $display("FAIL b2b_second: got v=%b d=%h c=%0d expected v=1 d=0022 c=9",
                        po_valid, po_data, frame_cnt);
            else pass_cnt++;
         end
      end
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      cfg_length = 2'b11; cfg_msb = 1'b1;
      send_bit(1'b1);
      si_end = 1'b1;
      send_bits(32'hFFFF_FFFF, 32, 1'b1, 9);
      si_end = 1'b0;
      total_cnt++;
      if (rx_done !== 1'b0) $display("FAIL end_in_recv: got %b expected 0", rx_done);
      else pass_cnt++;
      si_valid = 1'b0;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (po_data !== 16'h0000 || frame_cnt !== 16'd0 || po_valid !== 1'b0 || rx_done !== 1'b0)
         $display("FAIL mid_reset: got d=%h c=%0d v=%b r=%b expected all 0",
                  po_data, frame_cnt, po_valid, rx_done);
      else pass_cnt++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle_cycle();
      idle_cycle();
      total_cnt++;
      if (po_valid !== 1'b0 || frame_err !== 1'b0)
         $display("FAIL post_reset: got v=%b e=%b expected v=0 e=0", po_valid, frame_err);
      else pass_cnt++;
      si_end = 1'b1;
      idle_cycle();
      si_end = 1'b0;
      total_cnt++;
      if (rx_done !== 1'b1) $display("FAIL rx_done_set: got %b expected 1", rx_done);
      else pass_cnt++;
      repeat (3) idle_cycle();
      total_cnt++;
      if (rx_done !== 1'b1) $display("FAIL rx_done_sticky: got %b expected 1", rx_done);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b0; si_data = 1'b0; si_valid = 1'b0; si_end = 1'b0;
      cfg_length = 2'b00; cfg_msb = 1'b0; cfg_fill = 1'b0; cfg_low = 1'b0;
      test_reset();
      test_16b_msb();
      test_8b_lsb();
      test_pad();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
